// File: rtl/tc_fetch_pkg.sv
// Shared types and constants for the byte-serial instruction fetch unit.
package tc_fetch_pkg;
    localparam int unsigned ADDR_W          = 8;
    localparam int unsigned MAX_INSTR_BYTES = 4;
    localparam int unsigned IDX_W           = 2;

    typedef enum logic {
        FETCH,
        HOLD
    } state_t;
endpackage

// File: rtl/tc_fetch_pc.sv
// Program counter and byte index for the fetch unit; jumps win over
// acceptance, and all address arithmetic wraps modulo 256.
module tc_fetch_pc
    import tc_fetch_pkg::*;
#(
    parameter int unsigned         INSTR_BYTES = 4,
    parameter logic [ADDR_W-1:0]   RESET_PC    = 8'h00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              advance,
    input  logic              accept,
    input  logic              jump_valid,
    input  logic [ADDR_W-1:0] jump_target,
    output logic [ADDR_W-1:0] pc,
    output logic [IDX_W-1:0]  idx,
    output logic              last,
    output logic [ADDR_W-1:0] addr
);
    assign last = (idx == IDX_W'(INSTR_BYTES - 1));
    assign addr = pc + ADDR_W'(idx);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc  <= RESET_PC;
            idx <= '0;
        end else if (jump_valid) begin
            pc  <= jump_target;
            idx <= '0;
        end else if (accept) begin
            pc  <= pc + ADDR_W'(INSTR_BYTES);
            idx <= '0;
        end else if (advance) begin
            // idx parks at 0 while holding, so mem_addr then points at pc
            idx <= last ? '0 : idx + 1'b1;
        end
    end
endmodule

// File: rtl/tc_fetch_unit.sv
// Byte-serial instruction fetch: assembles INSTR_BYTES program bytes into a
// 32-bit word and holds it under a valid/ready handshake.
module tc_fetch_unit
    import tc_fetch_pkg::*;
#(
    parameter int unsigned       INSTR_BYTES = 4,
    parameter logic [7:0]        RESET_PC    = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    output logic [7:0]  mem_addr,
    input  logic [7:0]  mem_data,
    output logic [31:0] instr,
    output logic [7:0]  instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        jump_valid,
    input  logic [7:0]  jump_target
);
    state_t             state_q, state_d;
    logic [31:0]        buf_q;
    logic [ADDR_W-1:0]  pc;
    logic [IDX_W-1:0]   idx;
    logic               last;
    logic               advance;
    logic               accept;

    assign advance = (state_q == FETCH);
    assign accept  = (state_q == HOLD) && instr_ready;

    tc_fetch_pc #(
        .INSTR_BYTES (INSTR_BYTES),
        .RESET_PC    (RESET_PC)
    ) u_pc (
        .clk         (clk),
        .rst         (rst),
        .advance     (advance),
        .accept      (accept),
        .jump_valid  (jump_valid),
        .jump_target (jump_target),
        .pc          (pc),
        .idx         (idx),
        .last        (last),
        .addr        (mem_addr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (jump_valid) begin
            state_d = FETCH;
        end else begin
            case (state_q)
                FETCH:   if (last) state_d = HOLD;
                HOLD:    if (instr_ready) state_d = FETCH;
                default: state_d = FETCH;
            endcase
        end
    end

    // Lanes beyond INSTR_BYTES are forced to zero every cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q <= '0;
        end else begin
            for (int unsigned i = 0; i < MAX_INSTR_BYTES; i++) begin
                if (i >= INSTR_BYTES) begin
                    buf_q[8*i +: 8] <= '0;
                end else if (state_q == FETCH && idx == IDX_W'(i)) begin
                    buf_q[8*i +: 8] <= mem_data;
                end
            end
        end
    end

    assign instr       = buf_q;
    assign instr_pc    = pc;
    assign instr_valid = (state_q == HOLD);
endmodule

// File: tb/tb_tc_fetch_unit.sv
// Bench for tc_fetch_unit: directed scenarios plus random traffic, checked
// every cycle against an age-based model of two instances (4-byte and 2-byte).
module tb_tc_fetch_unit;
    logic        clk;
    logic        rst;
    logic        instr_ready;
    logic        jump_valid;
    logic [7:0]  jump_target;
    logic [7:0]  rom [256];

    logic [7:0]  o_addr  [2];
    logic [7:0]  o_data  [2];
    logic [31:0] o_instr [2];
    logic [7:0]  o_ipc   [2];
    logic        o_valid [2];

    localparam int unsigned NB [2] = '{4, 2};
    localparam logic [7:0]  RP [2] = '{8'h00, 8'h10};

    int n_tests = 0;
    int n_fail  = 0;
    bit checking = 0;
    int acc4 = 0;

    // Model: an instruction becomes visible once NB cycles have elapsed since
    // the fetch started at m_pc; its value is simply the ROM bytes from m_pc.
    logic [7:0]  m_pc  [2];
    int unsigned m_age [2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign o_data[0] = rom[o_addr[0]];
    assign o_data[1] = rom[o_addr[1]];

    tc_fetch_unit #(.INSTR_BYTES(4), .RESET_PC(8'h00)) dut4 (
        .clk(clk), .rst(rst), .mem_addr(o_addr[0]), .mem_data(o_data[0]),
        .instr(o_instr[0]), .instr_pc(o_ipc[0]), .instr_valid(o_valid[0]),
        .instr_ready(instr_ready), .jump_valid(jump_valid), .jump_target(jump_target)
    );

    tc_fetch_unit #(.INSTR_BYTES(2), .RESET_PC(8'h10)) dut2 (
        .clk(clk), .rst(rst), .mem_addr(o_addr[1]), .mem_data(o_data[1]),
        .instr(o_instr[1]), .instr_pc(o_ipc[1]), .instr_valid(o_valid[1]),
        .instr_ready(instr_ready), .jump_valid(jump_valid), .jump_target(jump_target)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        if (!rst && o_valid[0] && instr_ready) acc4++;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_pc[d]  = RP[d];
                m_age[d] = 0;
            end else if (jump_valid) begin
                m_pc[d]  = jump_target;
                m_age[d] = 0;
            end else if (m_age[d] >= NB[d]) begin
                if (instr_ready) begin
                    m_pc[d]  = m_pc[d] + 8'(NB[d]);
                    m_age[d] = 0;
                end
            end else begin
                m_age[d] = m_age[d] + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            for (int d = 0; d < 2; d++) begin
                logic [31:0] exp_instr;
                logic        exp_valid;
                exp_valid = (m_age[d] >= NB[d]);
                exp_instr = '0;
                for (int k = 0; k < int'(NB[d]); k++)
                    exp_instr |= 32'(rom[8'(m_pc[d] + 8'(k))]) << (8 * k);
                chk(d == 0 ? "valid4" : "valid2", 32'(o_valid[d]), 32'(exp_valid));
                if (exp_valid) begin
                    chk(d == 0 ? "instr4" : "instr2", o_instr[d], exp_instr);
                    chk(d == 0 ? "ipc4" : "ipc2", 32'(o_ipc[d]), 32'(m_pc[d]));
                end else begin
                    chk(d == 0 ? "addr4" : "addr2", 32'(o_addr[d]),
                        32'(8'(m_pc[d] + 8'(m_age[d]))));
                end
            end
            chk("instr2_upper", 32'(o_instr[1][31:16]), 32'h0);
        end
    end

    initial begin
        int a0;
        m_pc  = '{8'h00, 8'h10};
        m_age = '{0, 0};
        for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
        rom[8'h00] = 8'h11; rom[8'h01] = 8'h22; rom[8'h02] = 8'h33; rom[8'h03] = 8'h44;
        rst = 1'b1; instr_ready = 1'b1; jump_valid = 1'b0; jump_target = 8'h00;

        // Reset, then first fetch with ready held high through the fetch
        tick();
        rst = 1'b0;
        checking = 1;
        chk("rst_addr4", 32'(o_addr[0]), 32'h00);
        chk("rst_addr2", 32'(o_addr[1]), 32'h10);
        chk("rst_valid4", 32'(o_valid[0]), 32'h0);
        chk("rst_instr4", o_instr[0], 32'h0);
        chk("rst_ipc2", 32'(o_ipc[1]), 32'h10);
        repeat (4) tick();
        instr_ready = 1'b0;
        chk("s1_valid", 32'(o_valid[0]), 32'h1);
        chk("s1_instr", o_instr[0], 32'h44332211);
        chk("s1_ipc", 32'(o_ipc[0]), 32'h00);

        // Hold for 5 cycles, then accept once
        repeat (5) begin
            tick();
            chk("s2_hold_instr", o_instr[0], 32'h44332211);
            chk("s2_hold_valid", 32'(o_valid[0]), 32'h1);
        end
        a0 = acc4;
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        chk("s2_acc_once", 32'(acc4 - a0), 32'h1);
        chk("s2_valid_drop", 32'(o_valid[0]), 32'h0);
        chk("s2_next_addr", 32'(o_addr[0]), 32'h04);

        // Jump after two bytes of the next instruction
        repeat (2) tick();
        jump_valid = 1'b1; jump_target = 8'h80;
        tick();
        jump_valid = 1'b0;
        chk("s3_addr", 32'(o_addr[0]), 32'h80);
        repeat (4) tick();
        chk("s3_valid", 32'(o_valid[0]), 32'h1);
        chk("s3_ipc", 32'(o_ipc[0]), 32'h80);

        // Acceptance and jump in the same cycle
        a0 = acc4;
        instr_ready = 1'b1; jump_valid = 1'b1; jump_target = 8'h40;
        tick();
        instr_ready = 1'b0; jump_valid = 1'b0;
        chk("s5_acc_once", 32'(acc4 - a0), 32'h1);
        chk("s5_addr", 32'(o_addr[0]), 32'h40);
        repeat (4) tick();
        chk("s5_ipc", 32'(o_ipc[0]), 32'h40);

        // Wrap across FF -> 00 inside one instruction
        rst = 1'b1;
        rom[8'hFE] = 8'hAA; rom[8'hFF] = 8'hBB; rom[8'h00] = 8'hCC; rom[8'h01] = 8'hDD;
        tick();
        rst = 1'b0; jump_valid = 1'b1; jump_target = 8'hFE;
        tick();
        jump_valid = 1'b0;
        repeat (4) tick();
        chk("s4_instr", o_instr[0], 32'hDDCCBBAA);
        chk("s4_ipc", 32'(o_ipc[0]), 32'hFE);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        chk("s4_next_addr", 32'(o_addr[0]), 32'h02);

        // Reset while the 2-byte instance is holding
        jump_valid = 1'b1; jump_target = 8'h20;
        tick();
        jump_valid = 1'b0;
        repeat (2) tick();
        chk("s6_hold2", 32'(o_valid[1]), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("s6_valid2", 32'(o_valid[1]), 32'h0);
        chk("s6_addr2", 32'(o_addr[1]), 32'h10);

        // Random traffic
        for (int c = 0; c < 4000; c++) begin
            instr_ready = ($urandom_range(1) == 1);
            jump_valid  = ($urandom_range(19) == 0);
            jump_target = 8'($urandom);
            rst         = ($urandom_range(99) == 0);
            tick();
        end
        rst = 1'b0; jump_valid = 1'b0; instr_ready = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/tc_fetch_unit.md
TC_FETCH_UNIT -- requirements
Module: tc_fetch_unit

Interface
REQ-001 SHALL have parameter INSTR_BYTES, default 4: number of program bytes per instruction, legal range 1..4.
REQ-002 SHALL have parameter RESET_PC, default 8'h00: program counter value after reset.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port mem_addr  output  8  byte address to the program memory.
REQ-006 SHALL have port mem_data  input  8  byte returned by the program memory, combinational, same cycle as mem_addr.
REQ-007 SHALL have port instr  output  32  assembled instruction; bytes beyond INSTR_BYTES read as zero.
REQ-008 SHALL have port instr_pc  output  8  address of the first byte of instr.
REQ-009 SHALL have port instr_valid  output  1  instr and instr_pc are valid.
REQ-010 SHALL have port instr_ready  input  1  downstream decoder accepts instr this cycle.
REQ-011 SHALL have port jump_valid  input  1  redirect request.
REQ-012 SHALL have port jump_target  input  8  new program counter for the redirect.

Function
REQ-013 SHALL keep registers pc[7:0], idx (0..INSTR_BYTES-1), a 32-bit byte buffer and state in {FETCH, HOLD}.
REQ-014 SHALL drive mem_addr = (pc + idx) mod 256, combinationally, in every state.
REQ-015 In FETCH, each cycle SHALL latch mem_data into buffer byte lane idx (lane 0 = instr[7:0]) and increment idx.
REQ-016 When the byte at idx = INSTR_BYTES-1 is latched, SHALL move to HOLD with instr_valid=1 on the next cycle, so that instr_valid rises INSTR_BYTES cycles after FETCH entry.
REQ-017 In HOLD, instr, instr_pc and instr_valid SHALL remain stable until instr_valid && instr_ready.
REQ-018 On acceptance in HOLD, SHALL set pc = (pc + INSTR_BYTES) mod 256 and idx = 0, return to FETCH and drop instr_valid on the next cycle.
REQ-019 instr_pc SHALL equal pc while in HOLD.
REQ-020 instr_ready outside HOLD SHALL be ignored.
REQ-021 jump_valid SHALL have priority in any state: next cycle pc = jump_target, idx = 0, state = FETCH, instr_valid = 0, and partially fetched bytes are discarded.
REQ-022 A jump in the same cycle as an acceptance SHALL count as the acceptance and the redirect both; pc SHALL take jump_target, not pc + INSTR_BYTES.
REQ-023 Address arithmetic SHALL wrap modulo 256, including within a multi-byte instruction (for example, bytes at FE, FF, 00, 01).
REQ-024 Buffer lanes at or beyond INSTR_BYTES SHALL be held at zero.

Reset
REQ-025 When rst=1 at a rising edge, SHALL set pc = RESET_PC, idx = 0, state = FETCH, buffer = 0, instr_valid = 0, instr = 0 and instr_pc = RESET_PC.
REQ-026 rst SHALL take priority over jump_valid and instr_ready, and SHALL abort any fetch or hold in progress.
REQ-027 mem_addr SHALL equal RESET_PC in the first cycle after reset.

Structure
REQ-028 Package tc_fetch_pkg SHALL hold the state enum (FETCH, HOLD) and the constants for address width 8 and maximum instruction bytes 4.
REQ-029 The PC and idx update, with wrap and jump priority, SHALL be a sub-module tc_fetch_pc; the buffer and handshake SHALL stay in the top module.
REQ-030 The block SHALL contain no memory; it SHALL connect to the 256-byte program ROM through mem_addr and mem_data only.

Verification
REQ-031 Scenario: reset, ROM 00..03 = 11 22 33 44, ready=1 -> after 4 cycles instr_valid=1, instr=32'h44332211, instr_pc=00; next mem_addr=04.
REQ-032 Scenario: ready=0 for 5 cycles while in HOLD -> instr stays 32'h44332211 and instr_valid stays 1; ready=1 -> accepted once, then fetch from 04.
REQ-033 Scenario: jump_valid=1 with target=80 after 2 bytes are fetched -> those bytes are discarded, mem_addr=80 next cycle, and the first valid instr_pc is 80.
REQ-034 Scenario: jump to FE with ROM FE, FF, 00, 01 = AA BB CC DD -> instr=32'hDDCCBBAA and instr_pc=FE; next pc=02.
REQ-035 Scenario: acceptance and jump to 40 in the same cycle -> exactly one acceptance, and the next instr_pc is 40.
REQ-036 Scenario: INSTR_BYTES=2, then rst asserted while in HOLD -> instr_valid=0 and mem_addr=RESET_PC the next cycle; upper 16 bits of instr are always 0.
